// File: rtl/scan_display_ctrl_if.sv
// Load/ack handshake between the BCD value producer and the
// display scheduler.
interface scan_display_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value_in;
    logic                  load_ack;

    modport master (
        output load,
        output value_in,
        input  load_ack
    );

    modport slave (
        input  load,
        input  value_in,
        output load_ack
    );
endinterface

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed digit scheduler feeding one shared BCD-to-7-segment
// decoder; new values are swapped in only at frame boundaries.
module scan_display_ctrl #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000,
    parameter int GUARD  = 2
) (
    input  logic                clk,
    input  logic                rst,
    scan_display_ctrl_if.slave  host,
    input  logic                blank_lz,
    output logic [3:0]          bcd,
    output logic [DIGITS-1:0]   dig_en,
    output logic                frame_done
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*DIGITS-1:0]    disp;
    logic [4*DIGITS-1:0]    pend;
    logic                   pend_v;
    logic                   lz_en;
    logic                   ack_q;

    logic                   slot_end;
    logic                   boundary;
    logic [3:0]             cur_digit;
    logic                   upper_zero;

    assign slot_end   = (cnt == CNT_MAX);
    assign boundary   = slot_end && (idx == IDX_MAX);
    assign frame_done = boundary;
    assign host.load_ack = ack_q;

    // Slot timer and digit index; the frame ends when both wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Capture loads into pend; commit to disp only at the boundary edge
    // so a frame never mixes digits from two values.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp   <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            lz_en  <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (host.load) begin
                pend <= host.value_in;
            end
            if (boundary) begin
                lz_en <= blank_lz;
                if (host.load) begin
                    disp   <= host.value_in;
                    pend_v <= 1'b0;
                    ack_q  <= 1'b1;
                end else if (pend_v) begin
                    disp   <= pend;
                    pend_v <= 1'b0;
                    ack_q  <= 1'b1;
                end
            end else if (host.load) begin
                pend_v <= 1'b1;
            end
        end
    end

    // Pick the current digit and find whether it and everything above
    // it are zero, which is what leading-zero blanking keys on.
    always_comb begin
        cur_digit  = 4'h0;
        upper_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx) begin
                cur_digit = disp[4*k +: 4];
            end
            if (IW'(k) >= idx && disp[4*k +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
    end

    // Code to the decoder; digit 0 always shows so zero reads as "0".
    always_comb begin
        bcd = cur_digit;
        if (lz_en && idx != '0 && upper_zero) begin
            bcd = 4'hF;
        end
    end

    // One-hot enable, held off for the guard cycles of every slot.
    always_comb begin
        dig_en = '0;
        if (cnt >= GUARD_C) begin
            dig_en[idx] = 1'b1;
        end
    end

endmodule
